usb_tx: RTL

FT245-style host-bound transmitter: the write-side counterpart of the USB command receiver. Buffers status/readback bytes from the fabric in a small FIFO and writes them to the host chip over the shared 8-bit bus, strobing `wr` when `txe` allows it. Drives `si_n` (send-immediate) on request to flush the host chip's buffer. Sits beside the receiver on the 100 MHz domain; the top level merges `d_out`/`d_oe` onto the `d` inout.

---
 rtl/usb_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/usb_tx.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/usb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | usb_pkg : shared FSM state, timing defaults and byte width for the  |
// |           FT245-style USB bus blocks.          Rev 1.0              |
// +--------------------------------------------------------------------+
package usb_pkg;

   localparam int BYTE_W          = 8;
   localparam int DEF_FIFO_DEPTH  = 16;
   localparam int DEF_SETUP_CYC   = 2;
   localparam int DEF_WR_CYC      = 6;
   localparam int DEF_RECOVER_CYC = 8;
   localparam int DEF_SI_TIMEOUT  = 1000;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_STROBE  = 3'd2,
      ST_HOLD    = 3'd3,
      ST_RECOVER = 3'd4,
      ST_SI      = 3'd5
   } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_fifo : first-word-fall-through FIFO, power-of-two depth,       |
// |             synchronous active-high reset.     Rev 1.0              |
// +--------------------------------------------------------------------+
module sync_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             full,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_wr;
   logic             do_rd;

   assign full    = (count == CNT_FULL);
   assign empty   = (count == '0);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_wr, do_rd})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/usb_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | usb_tx : FT245-style host-bound byte writer with send-immediate.    |
// |          Optional auto send-immediate: define USB_TX_AUTO_SI_EN.    |
// |          Rev 1.0                                                    |
// +--------------------------------------------------------------------+
module usb_tx
   import usb_pkg::*;
#(
   parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
   parameter int SETUP_CYC   = DEF_SETUP_CYC,
   parameter int WR_CYC      = DEF_WR_CYC,
   parameter int RECOVER_CYC = DEF_RECOVER_CYC,
   parameter int SI_TIMEOUT  = DEF_SI_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BYTE_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              flush,
   input  logic              txe,
   input  logic              rx_active,
   output logic              tx_active,
   output logic [BYTE_W-1:0] d_out,
   output logic              d_oe,
   output logic              wr,
   output logic              si_n
);

   localparam logic [15:0] SETUP_LOAD   = 16'(SETUP_CYC - 1);
   localparam logic [15:0] WR_LOAD      = 16'(WR_CYC - 1);
   localparam logic [15:0] RECOVER_LOAD = 16'(RECOVER_CYC - 1);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || SETUP_CYC < 1 ||
       WR_CYC < 1 || RECOVER_CYC < 1 || SI_TIMEOUT < 1) begin : g_param_check
      $error("usb_tx: illegal parameter value");
   end

   tx_state_t         state;
   logic [15:0]       tcnt;
   logic              tcnt_done;
   logic              flush_flag;
   logic              auto_si;
   logic              fifo_full;
   logic              fifo_empty;
   logic              pop;
   logic [BYTE_W-1:0] head;

   assign in_ready  = !fifo_full;
   assign pop       = (state == ST_HOLD);
   assign tcnt_done = (tcnt == '0);

   sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (BYTE_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (in_valid),
      .wr_data (in_data),
      .full    (fifo_full),
      .rd_en   (pop),
      .rd_data (head),
      .empty   (fifo_empty)
   );

`ifdef USB_TX_AUTO_SI_EN
   localparam int AW = $clog2(SI_TIMEOUT + 1);
   localparam logic [AW-1:0] SI_LIMIT = AW'(SI_TIMEOUT);
   localparam logic [AW-1:0] IDLE_ONE = AW'(1);

   logic [AW-1:0] idle_cnt;
   logic          written;

   // Counter saturates at the limit and is cleared once the SI it caused starts.
   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt <= '0;
         written  <= 1'b0;
      end else if (in_valid && in_ready) begin
         idle_cnt <= '0;
         written  <= 1'b1;
      end else if (state == ST_SI) begin
         idle_cnt <= '0;
         written  <= 1'b0;
      end else if (state == ST_IDLE && fifo_empty && written && !flush_flag &&
                   idle_cnt != SI_LIMIT) begin
         idle_cnt <= idle_cnt + IDLE_ONE;
      end
   end

   assign auto_si = (idle_cnt == SI_LIMIT);
`else
   assign auto_si = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         tcnt       <= '0;
         flush_flag <= 1'b0;
         wr         <= 1'b0;
         si_n       <= 1'b1;
         d_oe       <= 1'b0;
         d_out      <= '0;
         tx_active  <= 1'b0;
      end else begin
         // The clear on SI exit below overrides a coincident set.
         if (flush || auto_si) flush_flag <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (!rx_active) begin
                  if (!fifo_empty && !txe) begin
                     state     <= ST_SETUP;
                     tcnt      <= SETUP_LOAD;
                     d_oe      <= 1'b1;
                     d_out     <= head;
                     tx_active <= 1'b1;
                  end else if (fifo_empty && flush_flag) begin
                     state     <= ST_SI;
                     tcnt      <= WR_LOAD;
                     si_n      <= 1'b0;
                     tx_active <= 1'b1;
                  end
               end
            end
            ST_SETUP: begin
               if (tcnt_done) begin
                  state <= ST_STROBE;
                  tcnt  <= WR_LOAD;
                  wr    <= 1'b1;
               end else begin
                  tcnt <= tcnt - 16'd1;
               end
            end
            ST_STROBE: begin
               if (tcnt_done) begin
                  state <= ST_HOLD;
                  wr    <= 1'b0;
               end else begin
                  tcnt <= tcnt - 16'd1;
               end
            end
            ST_HOLD: begin
               state     <= ST_RECOVER;
               tcnt      <= RECOVER_LOAD;
               d_oe      <= 1'b0;
               tx_active <= 1'b0;
            end
            ST_RECOVER: begin
               if (tcnt_done) state <= ST_IDLE;
               else           tcnt  <= tcnt - 16'd1;
            end
            ST_SI: begin
               if (tcnt_done) begin
                  state      <= ST_IDLE;
                  si_n       <= 1'b1;
                  tx_active  <= 1'b0;
                  flush_flag <= 1'b0;
               end else begin
                  tcnt <= tcnt - 16'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
